// File: rtl/ddr_burst_ctrl.sv
// ddr_burst_ctrl
//   Burst sequencer between the dual-clock FIFO controller and the DDR2
//   controller local interface. Takes one write or read burst at a time,
//   pops the write FIFO word by word, issues word-granular local commands,
//   forwards read returns to the read FIFO and pulses a finish strobe per
//   burst. Single clock domain (clk_ref).
//
//   Ports
//     clk_ref, rst                        clock, async active-high reset
//     wr_length/ddr_wr_req/ddr_wraddr     write burst request (length in words)
//     ddr_din, ddr_wr_ack                 write FIFO q / rdreq (one pulse per word)
//     ddr_wr_finish                       1-cycle pulse, write burst complete
//     rd_length/ddr_rd_req/ddr_rdaddr     read burst request
//     ddr_dout, ddr_rd_ack                read FIFO data / wrreq
//     ddr_rd_finish                       1-cycle pulse, all read words delivered
//     local_*                             DDR2 controller local interface
module ddr_burst_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 25,
   parameter int unsigned LEN_W  = 10,
   parameter int unsigned GAP    = 2
) (
   input  logic              clk_ref,
   input  logic              rst,
   input  logic [LEN_W-1:0]  wr_length,
   input  logic [LEN_W-1:0]  rd_length,
   input  logic              ddr_wr_req,
   input  logic [ADDR_W-1:0] ddr_wraddr,
   input  logic [DATA_W-1:0] ddr_din,
   output logic              ddr_wr_ack,
   output logic              ddr_wr_finish,
   input  logic              ddr_rd_req,
   input  logic [ADDR_W-1:0] ddr_rdaddr,
   output logic [DATA_W-1:0] ddr_dout,
   output logic              ddr_rd_ack,
   output logic              ddr_rd_finish,
   input  logic              local_init_done,
   input  logic              local_ready,
   output logic [ADDR_W-1:0] local_address,
   output logic              local_write_req,
   output logic              local_read_req,
   output logic [DATA_W-1:0] local_wdata,
   input  logic [DATA_W-1:0] local_rdata,
   input  logic              local_rdata_valid
);

   localparam int unsigned CNT_W = LEN_W + 1;
   localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WR_FIN,
      S_READ,
      S_RD_WAIT,
      S_RD_FIN,
      S_GAP
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  len;
   logic [CNT_W-1:0]  popped;     // FIFO words popped (write)
   logic [CNT_W-1:0]  accepted;   // commands accepted by the controller
   logic [CNT_W-1:0]  received;   // read returns seen
   logic              pend;       // a popped word is waiting for acceptance
   logic [GAP_W-1:0]  gap_cnt;
   logic              rd_ack_r;
   logic [DATA_W-1:0] dout_r;

   logic wr_ack;
   logic wr_accept;
   logic rd_issue;

   // A new word may be popped only when the previous one is either absent
   // or being accepted this cycle, so the command stays stable while stalled.
   assign wr_ack    = (state == S_WRITE) && (popped < len) && (!pend || local_ready);
   assign wr_accept = pend && local_ready;
   assign rd_issue  = (state == S_READ);

   assign ddr_wr_ack      = wr_ack;
   assign local_write_req = pend;
   assign local_read_req  = rd_issue;
   assign local_address   = base_addr + ADDR_W'(accepted);
   assign local_wdata     = (state == S_WRITE) ? ddr_din : '0;
   assign ddr_wr_finish   = (state == S_WR_FIN);
   assign ddr_rd_finish   = (state == S_RD_FIN);
   assign ddr_rd_ack      = rd_ack_r;
   assign ddr_dout        = dout_r;

   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         base_addr <= '0;
         len       <= '0;
         popped    <= '0;
         accepted  <= '0;
         received  <= '0;
         pend      <= 1'b0;
         gap_cnt   <= '0;
         rd_ack_r  <= 1'b0;
         dout_r    <= '0;
      end else begin
         // Read return path runs in every state.
         rd_ack_r <= local_rdata_valid;
         dout_r   <= local_rdata;
         if (local_rdata_valid) received <= received + 1'b1;

         case (state)
            S_IDLE: begin
               if (local_init_done && ddr_wr_req) begin
                  base_addr <= ddr_wraddr;
                  len       <= CNT_W'(wr_length);
                  popped    <= '0;
                  accepted  <= '0;
                  pend      <= 1'b0;
                  state     <= (wr_length == '0) ? S_WR_FIN : S_WRITE;
               end else if (local_init_done && ddr_rd_req) begin
                  base_addr <= ddr_rdaddr;
                  len       <= CNT_W'(rd_length);
                  popped    <= '0;
                  accepted  <= '0;
                  received  <= '0;
                  pend      <= 1'b0;
                  state     <= (rd_length == '0) ? S_RD_FIN : S_READ;
               end
            end

            S_WRITE: begin
               if (wr_ack)    popped   <= popped + 1'b1;
               if (wr_accept) accepted <= accepted + 1'b1;
               if (wr_ack)
                  pend <= 1'b1;
               else if (local_ready)
                  pend <= 1'b0;
               // pend only clears on acceptance, so this means all words accepted
               if (!pend && (popped == len)) state <= S_WR_FIN;
            end

            S_WR_FIN: begin
               gap_cnt <= '0;
               state   <= (GAP == 0) ? S_IDLE : S_GAP;
            end

            S_READ: begin
               if (local_ready) begin
                  accepted <= accepted + 1'b1;
                  if (accepted == (len - 1'b1)) state <= S_RD_WAIT;
               end
            end

            S_RD_WAIT: begin
               // received reaches len in the same cycle ddr_rd_ack shows the
               // last word, so RD_FIN lands one cycle after it
               if (received == len) state <= S_RD_FIN;
            end

            S_RD_FIN: begin
               gap_cnt <= '0;
               state   <= (GAP == 0) ? S_IDLE : S_GAP;
            end

            S_GAP: begin
               if (gap_cnt == GAP_W'(GAP - 1))
                  state <= S_IDLE;
               else
                  gap_cnt <= gap_cnt + 1'b1;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// Self-checking bench for ddr_burst_ctrl: directed bursts, a write FIFO and
// DDR controller model, and scoreboard queues of expected commands/returns.
module tb_ddr_burst_ctrl;

   localparam int DW = 32;
   localparam int AW = 25;
   localparam int LW = 10;

   logic          clk_ref = 1'b0;
   logic          rst;
   logic [LW-1:0] wr_length, rd_length;
   logic          ddr_wr_req, ddr_rd_req;
   logic [AW-1:0] ddr_wraddr, ddr_rdaddr;
   logic [DW-1:0] ddr_din;
   logic          ddr_wr_ack, ddr_wr_finish;
   logic [DW-1:0] ddr_dout;
   logic          ddr_rd_ack, ddr_rd_finish;
   logic          local_init_done;
   logic          local_ready = 1'b1;
   logic [AW-1:0] local_address;
   logic          local_write_req, local_read_req;
   logic [DW-1:0] local_wdata;
   logic [DW-1:0] local_rdata;
   logic          local_rdata_valid;

   always #5 clk_ref = ~clk_ref;

   ddr_burst_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .GAP(2)) dut (
      .clk_ref(clk_ref), .rst(rst),
      .wr_length(wr_length), .rd_length(rd_length),
      .ddr_wr_req(ddr_wr_req), .ddr_wraddr(ddr_wraddr), .ddr_din(ddr_din),
      .ddr_wr_ack(ddr_wr_ack), .ddr_wr_finish(ddr_wr_finish),
      .ddr_rd_req(ddr_rd_req), .ddr_rdaddr(ddr_rdaddr), .ddr_dout(ddr_dout),
      .ddr_rd_ack(ddr_rd_ack), .ddr_rd_finish(ddr_rd_finish),
      .local_init_done(local_init_done), .local_ready(local_ready),
      .local_address(local_address), .local_write_req(local_write_req),
      .local_read_req(local_read_req), .local_wdata(local_wdata),
      .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid)
   );

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
   typedef struct { logic [AW-1:0] a; int due; } rpend_t;

   wexp_t         wr_q[$];
   logic [AW-1:0] rd_addr_q[$];
   logic [DW-1:0] rd_data_q[$];
   logic [DW-1:0] wfifo[$];
   rpend_t        rpend[$];

   int cyc = 0, n_chk = 0, n_pass = 0, n_fail = 0;
   int ack_cnt = 0, ack_first = 0, ack_last = 0, wr_cmds = 0, wreq_cyc = 0;
   int wfin_cnt = 0, wfin_cyc = 0, rd_cmds = 0, rd_first = -1;
   int rdack_cnt = 0, rdack_last = 0, rfin_cnt = 0, rfin_cyc = 0;
   bit pop_pending = 0, stall_mode = 0;
   int wk = 0;
   logic prev_wstall = 1'b0;
   logic [AW+DW-1:0] prev_w;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return {7'h0, a} ^ 32'h5A5A_5A5A;
   endfunction

   function automatic logic [127:0] outs();
      return {ddr_wr_ack, ddr_wr_finish, ddr_dout, ddr_rd_ack, ddr_rd_finish,
              local_address, local_write_req, local_read_req, local_wdata};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor / scoreboard, sampled mid-cycle.
   always @(negedge clk_ref) begin : mon
      wexp_t e;
      rpend_t p;
      if (!rst) begin
         if (local_write_req || local_read_req)
            chk("req_excl", local_write_req & local_read_req, 1'b0);
         if (prev_wstall)
            chk("wr_hold", {local_write_req, local_address, local_wdata}, {1'b1, prev_w});
         prev_wstall = local_write_req && !local_ready;
         prev_w      = {local_address, local_wdata};
         if (local_write_req) begin
            wreq_cyc++;
            if (local_ready) begin
               wr_cmds++;
               if (wr_q.size() == 0) chk("wr_extra", 1, 0);
               else begin
                  e = wr_q.pop_front();
                  chk("wr_addr", local_address, e.a);
                  chk("wr_data", local_wdata, e.d);
               end
            end
         end
         if (local_read_req) begin
            if (rd_first < 0) rd_first = cyc;
            if (local_ready) begin
               rd_cmds++;
               if (rd_addr_q.size() == 0) chk("rd_extra", 1, 0);
               else chk("rd_addr", local_address, rd_addr_q.pop_front());
               p.a = local_address;
               p.due = cyc + 5;
               rpend.push_back(p);
            end
         end
         if (ddr_wr_ack) begin
            if (ack_cnt == 0) ack_first = cyc;
            ack_last = cyc;
            ack_cnt++;
            pop_pending = 1;
         end
         if (ddr_rd_ack) begin
            rdack_cnt++;
            rdack_last = cyc;
            if (rd_data_q.size() == 0) chk("rd_ack_extra", 1, 0);
            else chk("rd_dout", ddr_dout, rd_data_q.pop_front());
         end
         if (ddr_wr_finish) begin wfin_cnt++; wfin_cyc = cyc; end
         if (ddr_rd_finish) begin rfin_cnt++; rfin_cyc = cyc; end
      end else begin
         prev_wstall = 1'b0;
      end
   end

   // Write FIFO and DDR controller model (ready stalls, 5-cycle read latency).
   always @(posedge clk_ref) begin : resp
      rpend_t r;
      cyc++;
      #1;
      if (rst) begin
         rpend.delete();
         local_rdata_valid = 1'b0;
         pop_pending = 0;
         local_ready = 1'b1;
      end else begin
         if (pop_pending) begin
            if (wfifo.size() > 0) ddr_din = wfifo.pop_front();
            else ddr_din = 32'hDEAD_BEEF;
            pop_pending = 0;
         end
         if (rpend.size() > 0 && rpend[0].due <= cyc) begin
            r = rpend.pop_front();
            local_rdata = memf(r.a);
            local_rdata_valid = 1'b1;
         end else begin
            local_rdata_valid = 1'b0;
         end
         if (local_write_req) begin
            wk++;
            local_ready = !(stall_mode && (wk == 2 || wk == 3));
         end else begin
            local_ready = 1'b1;
         end
      end
   end

   initial begin
      int fin1, fin4, k, rf, ra, rc;
      logic [AW-1:0] a;
      wexp_t w;
      rst = 1'b1; local_init_done = 1'b0; ddr_wr_req = 1'b0; ddr_rd_req = 1'b0;
      wr_length = '0; rd_length = '0; ddr_wraddr = '0; ddr_rdaddr = '0;
      ddr_din = '0; local_rdata = '0; local_rdata_valid = 1'b0;
      #3;
      chk("reset_outputs", outs(), '0);
      repeat (3) @(posedge clk_ref);
      #1 rst = 1'b0;

      // Requests ignored until calibration is done
      wr_length = 10'd4; ddr_wraddr = 25'h100; ddr_wr_req = 1'b1;
      ack_cnt = 0; wreq_cyc = 0;
      repeat (5) @(posedge clk_ref);
      #1;
      chk("init_gate_ack", ack_cnt, 0);
      chk("init_gate_req", wreq_cyc, 0);
      ddr_wr_req = 1'b0; local_init_done = 1'b1;
      @(posedge clk_ref); #1;

      // Write 4 words at 0x100, always ready
      for (int i = 0; i < 4; i++) begin
         wfifo.push_back(32'hC0DE_0100 + i);
         w.a = 25'h100 + i; w.d = 32'hC0DE_0100 + i;
         wr_q.push_back(w);
      end
      ack_cnt = 0; wr_cmds = 0; wreq_cyc = 0; wfin_cnt = 0;
      wr_length = 10'd4; ddr_wraddr = 25'h100; ddr_wr_req = 1'b1;
      @(posedge clk_ref); #1;
      ddr_wr_req = 1'b0; ddr_wraddr = 25'h1AB_CDE; wr_length = 10'd7;
      for (int n = 0; n < 100 && wfin_cnt < 1; n++) @(posedge clk_ref);
      #1;
      chk("w1_finish", wfin_cnt, 1);
      chk("w1_acks", ack_cnt, 4);
      chk("w1_ack_consec", ack_last - ack_first, 3);
      chk("w1_cmds", wr_cmds, 4);
      chk("w1_q_empty", wr_q.size(), 0);
      fin1 = wfin_cyc;

      // Zero-length write, requested during GAP: shows GAP=2 spacing
      ack_cnt = 0; wr_cmds = 0; wreq_cyc = 0;
      wr_length = '0; ddr_wr_req = 1'b1;
      for (int n = 0; n < 100 && wfin_cnt < 2; n++) @(posedge clk_ref);
      #1;
      ddr_wr_req = 1'b0;
      chk("w0_finish", wfin_cnt, 2);
      chk("gap_spacing", wfin_cyc - fin1, 4);
      chk("w0_acks", ack_cnt, 0);
      chk("w0_wreq", wreq_cyc, 0);
      repeat (4) @(posedge clk_ref); #1;

      // Write 4 words at 0x200 with ready low on 2nd and 3rd command cycles
      for (int i = 0; i < 4; i++) begin
         wfifo.push_back(32'hC0DE_0200 + i);
         w.a = 25'h200 + i; w.d = 32'hC0DE_0200 + i;
         wr_q.push_back(w);
      end
      stall_mode = 1; wk = 0;
      ack_cnt = 0; wr_cmds = 0; wreq_cyc = 0;
      wr_length = 10'd4; ddr_wraddr = 25'h200; ddr_wr_req = 1'b1;
      @(posedge clk_ref); #1;
      ddr_wr_req = 1'b0;
      for (int n = 0; n < 100 && wfin_cnt < 3; n++) @(posedge clk_ref);
      #1;
      stall_mode = 0;
      chk("w2_finish", wfin_cnt, 3);
      chk("w2_acks", ack_cnt, 4);
      chk("w2_cmds", wr_cmds, 4);
      chk("w2_req_cycles", wreq_cyc, 6);
      chk("w2_q_empty", wr_q.size(), 0);
      repeat (4) @(posedge clk_ref); #1;

      // Read 8 words at 0x2000
      for (int i = 0; i < 8; i++) begin
         a = 25'h2000 + i;
         rd_addr_q.push_back(a);
         rd_data_q.push_back(memf(a));
      end
      rd_cmds = 0; rdack_cnt = 0; rfin_cnt = 0;
      rd_length = 10'd8; ddr_rdaddr = 25'h2000; ddr_rd_req = 1'b1;
      @(posedge clk_ref); #1;
      ddr_rd_req = 1'b0; ddr_rdaddr = 25'h0BAD; rd_length = 10'd3;
      for (int n = 0; n < 200 && rfin_cnt < 1; n++) @(posedge clk_ref);
      #1;
      chk("r1_finish", rfin_cnt, 1);
      chk("r1_cmds", rd_cmds, 8);
      chk("r1_acks", rdack_cnt, 8);
      chk("r1_fin_timing", rfin_cyc - rdack_last, 1);
      chk("r1_q_empty", rd_addr_q.size() + rd_data_q.size(), 0);
      repeat (4) @(posedge clk_ref); #1;

      // Simultaneous requests: write first, read (wrapping address) after GAP
      for (int i = 0; i < 2; i++) begin
         wfifo.push_back(32'hC0DE_0300 + i);
         w.a = 25'h300 + i; w.d = 32'hC0DE_0300 + i;
         wr_q.push_back(w);
         a = 25'h1FF_FFFF + i;
         rd_addr_q.push_back(a);
         rd_data_q.push_back(memf(a));
      end
      rd_first = -1; rd_cmds = 0;
      wr_length = 10'd2; ddr_wraddr = 25'h300; rd_length = 10'd2; ddr_rdaddr = 25'h1FF_FFFF;
      ddr_wr_req = 1'b1; ddr_rd_req = 1'b1;
      for (int n = 0; n < 100 && wfin_cnt < 4; n++) @(posedge clk_ref);
      #1;
      ddr_wr_req = 1'b0;
      fin4 = wfin_cyc;
      for (int n = 0; n < 100 && rd_cmds < 1; n++) @(posedge clk_ref);
      #1;
      ddr_rd_req = 1'b0;
      for (int n = 0; n < 200 && rfin_cnt < 2; n++) @(posedge clk_ref);
      #1;
      chk("both_wfin", wfin_cnt, 4);
      chk("both_rfin", rfin_cnt, 2);
      chk("both_rd_start", rd_first - fin4, 4);
      chk("both_rd_cmds", rd_cmds, 2);
      chk("both_q_empty", wr_q.size() + rd_addr_q.size() + rd_data_q.size(), 0);
      repeat (4) @(posedge clk_ref); #1;

      // Reset on the 3rd return of an 8-word read
      for (int i = 0; i < 8; i++) begin
         a = 25'h3000 + i;
         rd_addr_q.push_back(a);
         rd_data_q.push_back(memf(a));
      end
      rd_length = 10'd8; ddr_rdaddr = 25'h3000; ddr_rd_req = 1'b1;
      @(posedge clk_ref); #1;
      ddr_rd_req = 1'b0;
      k = 0;
      for (int n = 0; n < 100 && k < 3; n++) begin
         @(posedge clk_ref); #2;
         if (local_rdata_valid) k++;
      end
      chk("rst_3rd_return", k, 3);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", outs(), '0);
      rf = rfin_cnt; ra = rdack_cnt; rc = rd_cmds;
      repeat (3) @(posedge clk_ref); #1;
      rd_addr_q.delete(); rd_data_q.delete();
      rst = 1'b0;
      repeat (30) @(posedge clk_ref); #1;
      chk("rst_no_finish", rfin_cnt, rf);
      chk("rst_no_ack", rdack_cnt, ra);
      chk("rst_idle_no_cmd", rd_cmds, rc);
      chk("rst_idle_outputs", {local_read_req, local_write_req, ddr_rd_ack, ddr_wr_ack}, 4'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
